// File: rtl/arb_client_pkg.sv
// Shared types for the round-robin arbiter client port.
// Holds the FSM state encoding and the queued-job layout.
package arb_client_pkg;

   localparam int LEN_W      = 2;
   localparam int DATA_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      XFER,
      GAP
   } state_t;

   typedef struct packed {
      logic [LEN_W-1:0]      len;
      logic [DATA_W_DEF-1:0] data;
   } job_t;

endpackage

// File: rtl/arb_client_fifo.sv
// Small synchronous job FIFO with full/empty flags.
// Head entry is presented combinationally on rdata.
module arb_client_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;

   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);
   assign rdata = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/arb_client_port.sv
// Requester-side agent: queues jobs, requests the arbiter,
// streams granted beats and tracks starvation/spurious grants.
module arb_client_port
   import arb_client_pkg::*;
#(
   parameter int DATA_W       = DATA_W_DEF,
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [LEN_W-1:0]  in_len,
   output logic              req,
   input  logic              grant,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              busy,
   output logic              starve,
   output logic              err_spurious,
   input  logic              clr_status
);

   localparam int WW = $clog2(STARVE_LIMIT + 1);

   state_t             state_q, state_d;
   logic [LEN_W-1:0]   beat_q, beat_d, idx;
   logic               issue, last, pop, push;
   logic               full, empty;
   logic [LEN_W+DATA_W-1:0] head;
   logic [LEN_W-1:0]   head_len;
   logic [DATA_W-1:0]  head_data;
   logic [WW-1:0]      wait_q;
   logic               starve_set, spur_set;

   assign push      = in_valid & ~full;
   assign in_ready  = ~full;
   assign head_len  = head[DATA_W +: LEN_W];
   assign head_data = head[DATA_W-1:0];

   arb_client_fifo #(
      .WIDTH (LEN_W + DATA_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push),
      .wdata   ({in_len, in_data}),
      .pop     (pop),
      .rdata   (head),
      .full    (full),
      .empty   (empty)
   );

   assign req  = (state_q == REQ) || (state_q == XFER);
   assign busy = (state_q != IDLE) || !empty;

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      idx     = beat_q;
      issue   = 1'b0;
      last    = 1'b0;
      pop     = 1'b0;
      unique case (state_q)
         IDLE: if (!empty) state_d = REQ;
         REQ: if (grant) begin
            issue  = 1'b1;
            idx    = '0;
            beat_d = LEN_W'(1);
            if (head_len == '0) begin
               last    = 1'b1;
               pop     = 1'b1;
               state_d = GAP;
            end else begin
               state_d = XFER;
            end
         end
         XFER: if (grant) begin
            issue = 1'b1;
            if (beat_q == head_len) begin
               last    = 1'b1;
               pop     = 1'b1;
               state_d = GAP;
            end else begin
               beat_d = beat_q + 1'b1;
            end
         end
         GAP: state_d = empty ? IDLE : REQ;
         default: state_d = IDLE;
      endcase
   end

   // Flags set on the cycle the condition is observed; set beats clear.
   assign starve_set = req & ~grant &
                       (wait_q >= WW'(STARVE_LIMIT - 1));
   assign spur_set   = grant &
                       ((state_q == IDLE) || (state_q == GAP));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         beat_q       <= '0;
         out_valid    <= 1'b0;
         out_last     <= 1'b0;
         out_data     <= '0;
         wait_q       <= '0;
         starve       <= 1'b0;
         err_spurious <= 1'b0;
      end else begin
         state_q   <= state_d;
         beat_q    <= beat_d;
         out_valid <= issue;
         out_last  <= last;
         if (issue) out_data <= head_data + DATA_W'(idx);
         if (req && !grant) begin
            if (wait_q != WW'(STARVE_LIMIT)) wait_q <= wait_q + 1'b1;
         end else begin
            wait_q <= '0;
         end
         if (starve_set)      starve <= 1'b1;
         else if (clr_status) starve <= 1'b0;
         if (spur_set)        err_spurious <= 1'b1;
         else if (clr_status) err_spurious <= 1'b0;
      end
   end

endmodule

// File: tb/tb_arb_client_port.sv
// Directed self-checking bench for arb_client_port.
// Samples outputs 1 time unit after each rising edge.
module tb_arb_client_port;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic [1:0] in_len;
   logic       req;
   logic       grant;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_last;
   logic       busy;
   logic       starve;
   logic       err_spurious;
   logic       clr_status;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   arb_client_port #(
      .DATA_W       (8),
      .DEPTH        (4),
      .STARVE_LIMIT (16)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .in_len       (in_len),
      .req          (req),
      .grant        (grant),
      .out_valid    (out_valid),
      .out_data     (out_data),
      .out_last     (out_last),
      .busy         (busy),
      .starve       (starve),
      .err_spurious (err_spurious),
      .clr_status   (clr_status)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_outs(input string tag);
      chk({tag, " req"}, {31'd0, req}, 0);
      chk({tag, " out_valid"}, {31'd0, out_valid}, 0);
      chk({tag, " out_data"}, {24'd0, out_data}, 0);
      chk({tag, " out_last"}, {31'd0, out_last}, 0);
      chk({tag, " busy"}, {31'd0, busy}, 0);
      chk({tag, " in_ready"}, {31'd0, in_ready}, 1);
      chk({tag, " starve"}, {31'd0, starve}, 0);
      chk({tag, " err_spurious"}, {31'd0, err_spurious}, 0);
   endtask

   initial begin
      logic [7:0] exp_b [4];
      int k;
      bit g;
      reset_n    = 1'b0;
      in_valid   = 1'b0;
      in_data    = '0;
      in_len     = '0;
      grant      = 1'b0;
      clr_status = 1'b0;
      tick();
      chk_idle_outs("reset");
      reset_n = 1'b1;
      tick();

      // Job {2,0x10}, grant held from the first req cycle
      in_valid = 1'b1; in_data = 8'h10; in_len = 2'd2;
      tick();
      in_valid = 1'b0;
      chk("t1 req_after_push1", {31'd0, req}, 0);
      chk("t1 busy", {31'd0, busy}, 1);
      tick();
      chk("t1 req_after_push2", {31'd0, req}, 1);
      grant = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t1 valid", {31'd0, out_valid}, 1);
         chk("t1 data", {24'd0, out_data}, 32'h10 + i);
         chk("t1 last", {31'd0, out_last}, (i == 2) ? 1 : 0);
      end
      chk("t1 gap_req", {31'd0, req}, 0);
      grant = 1'b0;
      tick();
      chk("t1 idle_req", {31'd0, req}, 0);
      chk("t1 idle_busy", {31'd0, busy}, 0);
      chk("t1 hold_data", {24'd0, out_data}, 32'h12);
      chk("t1 idle_valid", {31'd0, out_valid}, 0);

      // Same job, grant pulsed every 4th cycle
      in_valid = 1'b1; in_data = 8'h10; in_len = 2'd2;
      tick();
      in_valid = 1'b0;
      tick();
      chk("t2 req", {31'd0, req}, 1);
      k = 0;
      for (int i = 0; i < 12; i++) begin
         g = (i % 4 == 3);
         grant = g;
         tick();
         chk("t2 valid", {31'd0, out_valid}, {31'd0, g});
         if (g) begin
            chk("t2 data", {24'd0, out_data}, 32'h10 + k);
            chk("t2 last", {31'd0, out_last}, (k == 2) ? 1 : 0);
            k++;
         end
         chk("t2 req", {31'd0, req}, (k < 3) ? 1 : 0);
      end
      grant = 1'b0;
      tick();
      chk("t2 idle", {31'd0, busy}, 0);

      // {3,0xFE} then {0,0x40} back-to-back, constant grant
      exp_b[0] = 8'hFE; exp_b[1] = 8'hFF;
      exp_b[2] = 8'h00; exp_b[3] = 8'h01;
      in_valid = 1'b1; in_data = 8'hFE; in_len = 2'd3;
      tick();
      in_data = 8'h40; in_len = 2'd0;
      tick();
      in_valid = 1'b0;
      chk("t3 req", {31'd0, req}, 1);
      grant = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t3 valid", {31'd0, out_valid}, 1);
         chk("t3 data", {24'd0, out_data}, {24'd0, exp_b[i]});
         chk("t3 last", {31'd0, out_last}, (i == 3) ? 1 : 0);
      end
      chk("t3 gap_req", {31'd0, req}, 0);
      grant = 1'b0;
      tick();
      chk("t3 req_again", {31'd0, req}, 1);
      chk("t3 gap_novalid", {31'd0, out_valid}, 0);
      grant = 1'b1;
      tick();
      chk("t3 data2", {24'd0, out_data}, 32'h40);
      chk("t3 last2", {31'd0, out_last}, 1);
      grant = 1'b0;
      tick();
      tick();
      chk("t3 idle", {31'd0, busy}, 0);
      chk("t3 no_spur", {31'd0, err_spurious}, 0);

      // Spurious grant while idle
      grant = 1'b1;
      tick();
      grant = 1'b0;
      chk("sp err", {31'd0, err_spurious}, 1);
      chk("sp valid", {31'd0, out_valid}, 0);
      tick();
      chk("sp req", {31'd0, req}, 0);
      chk("sp sticky", {31'd0, err_spurious}, 1);

      // Fill FIFO with grant low, then starvation
      in_valid = 1'b1; in_len = 2'd0; in_data = 8'hA0;
      tick();
      in_data = 8'hA1;
      tick();
      chk("t4 req", {31'd0, req}, 1);
      for (int n = 1; n <= 16; n++) begin
         if (n == 1) in_data = 8'hA2;
         if (n == 2) in_data = 8'hA3;
         if (n == 3) in_data = 8'hA4;
         tick();
         if (n == 1) chk("t4 ready3", {31'd0, in_ready}, 1);
         if (n == 2) chk("t4 ready4", {31'd0, in_ready}, 0);
         if (n == 5) chk("t4 held", {31'd0, in_ready}, 0);
         if (n == 15) chk("t4 starve15", {31'd0, starve}, 0);
         if (n == 16) chk("t4 starve16", {31'd0, starve}, 1);
      end
      in_valid = 1'b0;
      tick();
      chk("t4 sticky", {31'd0, starve}, 1);
      clr_status = 1'b1;
      grant = 1'b1;
      tick();
      clr_status = 1'b0;
      grant = 1'b0;
      chk("t4 clr_starve", {31'd0, starve}, 0);
      chk("t4 clr_spur", {31'd0, err_spurious}, 0);
      chk("t4 head_data", {24'd0, out_data}, 32'hA0);
      chk("t4 head_last", {31'd0, out_last}, 1);

      // Reset mid-XFER
      reset_n = 1'b0;
      #1;
      reset_n = 1'b1;
      in_valid = 1'b1; in_data = 8'h80; in_len = 2'd3;
      tick();
      in_valid = 1'b0;
      tick();
      grant = 1'b1;
      tick();
      tick();
      chk("t5 mid_valid", {31'd0, out_valid}, 1);
      chk("t5 mid_data", {24'd0, out_data}, 32'h81);
      reset_n = 1'b0;
      #1;
      chk_idle_outs("t5 async");
      grant = 1'b0;
      tick();
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t5 no_beat", {31'd0, out_valid}, 0);
         chk("t5 no_req", {31'd0, req}, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
